// File: rtl/speed_meas_pkg.sv
// Shared types and constants for the ring-oscillator speed-test reader.
package speed_meas_pkg;

  localparam int COUNT_W = 24;

  typedef enum logic [3:0] {
    IDLE, RSTDUT, ARM, TRIG, SETTLE, STOP, READ, CHECK, DONE
  } state_t;

  // Output-select codes for the speed-test out bus
  localparam logic [2:0] SEL_NONE   = 3'd0;
  localparam logic [2:0] SEL_C0_B0  = 3'd1;
  localparam logic [2:0] SEL_C0_B1  = 3'd2;
  localparam logic [2:0] SEL_C0_B2  = 3'd3;
  localparam logic [2:0] SEL_C1_B0  = 3'd4;
  localparam logic [2:0] SEL_C1_B1  = 3'd5;
  localparam logic [2:0] SEL_C1_B2  = 3'd6;
  localparam logic [2:0] SEL_STATUS = 3'd7;

  // err[] bit positions
  localparam int ERR_ARM      = 0;
  localparam int ERR_FIRE     = 1;
  localparam int ERR_RANGE    = 2;
  localparam int ERR_MISMATCH = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/speed_meas_check.sv
// Combinational sanity checks on the two captured down-counter values:
// range/overflow (too small, or MSB clear meaning the counter wrapped
// past half scale) and counter-to-counter mismatch.
module speed_meas_check
  import speed_meas_pkg::*;
#(
  parameter int MIN_COUNT = 10,
  parameter int MAX_DIFF  = 3
) (
  input  logic [COUNT_W-1:0] count0,
  input  logic [COUNT_W-1:0] count1,
  output logic               range_err,
  output logic               mismatch_err
);

  logic [COUNT_W-1:0] diff;

  // Unsigned magnitude of the difference, never wrapping
  always_comb begin
    diff         = (count0 >= count1) ? (count0 - count1) : (count1 - count0);
    range_err    = (count0 < COUNT_W'(MIN_COUNT)) || (count1 < COUNT_W'(MIN_COUNT)) ||
                   !count0[COUNT_W-1] || !count1[COUNT_W-1];
    mismatch_err = diff > COUNT_W'(MAX_DIFF);
  end

endmodule

// File: rtl/speed_meas_reader.sv
// Measurement sequencer for the ring-oscillator speed-test block: resets,
// arms, fires and stops the rings, then reads both 24-bit counters byte by
// byte and presents them with error flags on a valid/ready port.
// Optional macro SPEED_READER_TICKS_EN adds ticks0/ticks1/ticks_gt outputs.
module speed_meas_reader
  import speed_meas_pkg::*;
#(
  parameter int TRIG_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int FIRE_TIMEOUT  = 16,
  parameter int MIN_COUNT     = 10,
  parameter int MAX_DIFF      = 3
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [COUNT_W-1:0]  count0,
  output logic [COUNT_W-1:0]  count1,
  output logic [3:0]          err,
  output logic                st_nrst,
  output logic                st_trig,
  output logic [2:0]          st_sel,
  output logic [1:0]          st_ring_en,
  input  logic [7:0]          st_out
`ifdef SPEED_READER_TICKS_EN
  ,
  output logic [COUNT_W-1:0]  ticks0,
  output logic [COUNT_W-1:0]  ticks1,
  output logic [1:0]          ticks_gt
`endif
);

  localparam int CNT_MAX = max3(FIRE_TIMEOUT, SETTLE_CYCLES, TRIG_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, res_valid_q, res_valid_d;
  logic [COUNT_W-1:0] count0_q, count0_d, count1_q, count1_d;
  logic [3:0]         err_q, err_d;
  logic               st_nrst_q, st_nrst_d, st_trig_q, st_trig_d;
  logic [2:0]         st_sel_q, st_sel_d;
  logic [1:0]         st_ring_en_q, st_ring_en_d;
  logic               range_err, mismatch_err;

  speed_meas_check #(.MIN_COUNT(MIN_COUNT), .MAX_DIFF(MAX_DIFF)) u_check (
    .count0       (count0_q),
    .count1       (count1_q),
    .range_err    (range_err),
    .mismatch_err (mismatch_err)
  );

  // Next-state and next-output logic; every output is the flop of its _d
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    count0_d     = count0_q;
    count1_d     = count1_q;
    st_nrst_d    = st_nrst_q;
    st_trig_d    = 1'b0;
    st_sel_d     = st_sel_q;
    st_ring_en_d = st_ring_en_q;
    case (state_q)
      IDLE: if (start) begin
        state_d      = RSTDUT;
        err_d        = '0;
        st_nrst_d    = 1'b0;
        st_ring_en_d = 2'b00;
        st_sel_d     = SEL_NONE;
      end
      RSTDUT: begin
        state_d      = ARM;
        st_nrst_d    = 1'b1;
        st_ring_en_d = 2'b11;
        st_sel_d     = SEL_NONE;
      end
      ARM: if (|st_out[7:6]) begin
        err_d[ERR_ARM] = 1'b1;
        st_ring_en_d   = 2'b00;
        state_d        = DONE;
      end else begin
        state_d   = TRIG;
        st_trig_d = 1'b1;
        cnt_d     = '0;
      end
      TRIG: if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
        state_d = SETTLE;
        cnt_d   = '0;
      end else begin
        st_trig_d = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
      end
      SETTLE: if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
        state_d      = STOP;
        st_ring_en_d = 2'b00;
        st_sel_d     = SEL_STATUS;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      STOP: if (st_out[6]) begin
        state_d  = READ;
        st_sel_d = SEL_C0_B0;
        cnt_d    = '0;
      end else if (cnt_q == CNT_W'(FIRE_TIMEOUT - 1)) begin
        err_d[ERR_FIRE] = 1'b1;
        st_sel_d        = SEL_NONE;
        state_d         = DONE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // cnt_q[0] is the phase: 0 = select driven, 1 = bus settled, capture
      READ: if (!cnt_q[0]) begin
        cnt_d = CNT_W'(1);
      end else begin
        cnt_d = '0;
        case (st_sel_q)
          SEL_C0_B0: count0_d[7:0]   = st_out;
          SEL_C0_B1: count0_d[15:8]  = st_out;
          SEL_C0_B2: count0_d[23:16] = st_out;
          SEL_C1_B0: count1_d[7:0]   = st_out;
          SEL_C1_B1: count1_d[15:8]  = st_out;
          SEL_C1_B2: count1_d[23:16] = st_out;
          default: ;
        endcase
        if (st_sel_q == SEL_C1_B2) begin
          state_d  = CHECK;
          st_sel_d = SEL_NONE;
        end else begin
          st_sel_d = st_sel_q + 3'd1;
        end
      end
      CHECK: begin
        err_d[ERR_RANGE]    = range_err;
        err_d[ERR_MISMATCH] = mismatch_err;
        state_d             = DONE;
      end
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    res_valid_d = (state_d == DONE);
  end

  // State and registered outputs; async reset aborts any run in progress
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      count0_q     <= '0;
      count1_q     <= '0;
      err_q        <= '0;
      st_nrst_q    <= 1'b0;
      st_trig_q    <= 1'b0;
      st_sel_q     <= SEL_NONE;
      st_ring_en_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      res_valid_q  <= res_valid_d;
      count0_q     <= count0_d;
      count1_q     <= count1_d;
      err_q        <= err_d;
      st_nrst_q    <= st_nrst_d;
      st_trig_q    <= st_trig_d;
      st_sel_q     <= st_sel_d;
      st_ring_en_q <= st_ring_en_d;
    end
  end

  assign busy       = busy_q;
  assign res_valid  = res_valid_q;
  assign count0     = count0_q;
  assign count1     = count1_q;
  assign err        = err_q;
  assign st_nrst    = st_nrst_q;
  assign st_trig    = st_trig_q;
  assign st_sel     = st_sel_q;
  assign st_ring_en = st_ring_en_q;

`ifdef SPEED_READER_TICKS_EN
  logic [COUNT_W-1:0] ticks0_q, ticks0_d, ticks1_q, ticks1_d;
  logic [1:0]         ticks_gt_q, ticks_gt_d;

  // Elapsed ring ticks, latched alongside the CHECK flags
  always_comb begin
    ticks0_d   = ticks0_q;
    ticks1_d   = ticks1_q;
    ticks_gt_d = ticks_gt_q;
    if (state_q == CHECK) begin
      ticks0_d   = {COUNT_W{1'b1}} - count0_q;
      ticks1_d   = {COUNT_W{1'b1}} - count1_q;
      ticks_gt_d = (count0_q < count1_q) ? 2'b01 :
                   (count1_q < count0_q) ? 2'b10 : 2'b00;
    end
  end

  // Tick result registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ticks0_q   <= '0;
      ticks1_q   <= '0;
      ticks_gt_q <= '0;
    end else begin
      ticks0_q   <= ticks0_d;
      ticks1_q   <= ticks1_d;
      ticks_gt_q <= ticks_gt_d;
    end
  end

  assign ticks0   = ticks0_q;
  assign ticks1   = ticks1_q;
  assign ticks_gt = ticks_gt_q;
`endif

endmodule

// File: tb/tb_speed_meas_reader.sv
// Bench for speed_meas_reader with a behavioural speed-test block model.
module tb_speed_meas_reader;

  logic        clk = 1'b0, nrst = 1'b0, start = 1'b0, res_ready = 1'b0;
  logic        busy, res_valid, st_nrst, st_trig;
  logic [23:0] count0, count1;
  logic [3:0]  err;
  logic [2:0]  st_sel;
  logic [1:0]  st_ring_en;
  logic [7:0]  st_out;
`ifdef SPEED_READER_TICKS_EN
  logic [23:0] ticks0, ticks1;
  logic [1:0]  ticks_gt;
`endif

  speed_meas_reader dut (
    .clk(clk), .nrst(nrst), .start(start), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready),
    .count0(count0), .count1(count1), .err(err),
    .st_nrst(st_nrst), .st_trig(st_trig), .st_sel(st_sel),
    .st_ring_en(st_ring_en), .st_out(st_out)
`ifdef SPEED_READER_TICKS_EN
    , .ticks0(ticks0), .ticks1(ticks1), .ticks_gt(ticks_gt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // ---- Speed-test block model ----
  // Counters sit at FFFFFF until triggered, then hold the programmed final
  // count. Fired appears m_delay cycles after the rings are stopped.
  logic [23:0] m_c0 = '0, m_c1 = '0;
  bit          m_fire_en = 1'b1, m_arm_bad = 1'b0;
  int          m_delay = 0;
  logic        m_seen = 1'b0;
  int          m_dly = 0;
  logic        m_fired;
  logic [23:0] m_q0, m_q1;

  assign m_fired = m_seen && m_fire_en && (m_dly == 0);
  assign m_q0 = m_seen ? m_c0 : 24'hFFFFFF;
  assign m_q1 = m_seen ? m_c1 : 24'hFFFFFF;

  always @(posedge clk) begin
    if (!st_nrst) begin
      m_seen <= 1'b0;
      m_dly  <= 0;
    end else if (st_trig) begin
      m_seen <= 1'b1;
      m_dly  <= m_delay;
    end else if (m_seen && st_ring_en == 2'b00 && m_dly > 0) begin
      m_dly <= m_dly - 1;
    end
  end

  always_comb begin
    case (st_sel)
      3'd1: st_out = m_q0[7:0];
      3'd2: st_out = m_q0[15:8];
      3'd3: st_out = m_q0[23:16];
      3'd4: st_out = m_q1[7:0];
      3'd5: st_out = m_q1[15:8];
      3'd6: st_out = m_q1[23:16];
      3'd7: st_out = {1'b1, m_fired, 6'b0};
      default: st_out = m_arm_bad ? 8'h40 : 8'h00;
    endcase
  end

  // ---- Checking helpers ----
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Error flags from the sanity rules, in plain arithmetic
  function automatic logic [3:0] ref_err(input logic [23:0] a, input logic [23:0] b);
    longint la, lb, d;
    logic [3:0] r;
    la = a; lb = b;
    d  = (la > lb) ? la - lb : lb - la;
    r  = 4'b0000;
    r[2] = (la < 10) || (lb < 10) || (la < 64'h800000) || (lb < 64'h800000);
    r[3] = d > 3;
    return r;
  endfunction

  typedef struct {
    logic [23:0] c0, c1;
    bit          fire_en, arm_bad;
    int          delay;
    logic [3:0]  err;
    int          lat;
    logic [23:0] e0, e1;
  } vec_t;

  vec_t        tbl[11];
  logic [23:0] prev0 = '0, prev1 = '0;
  logic [23:0] exp_t0 = '0, exp_t1 = '0;
  logic [1:0]  exp_gt = '0;

  task automatic run_meas(input vec_t v, output int lat);
    m_c0 = v.c0; m_c1 = v.c1; m_fire_en = v.fire_en; m_arm_bad = v.arm_bad; m_delay = v.delay;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      else begin @(posedge clk); #1; end
      if (res_valid) begin lat = i; break; end
    end
  endtask

  task automatic accept();
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    chk("accept_valid_low", res_valid, 0);
    chk("accept_busy_low", busy, 0);
  endtask

  task automatic verify(input string tag, input vec_t v);
    int lat;
    run_meas(v, lat);
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_err"}, err, v.err);
    chk({tag, "_count0"}, count0, v.e0);
    chk({tag, "_count1"}, count1, v.e1);
    chk({tag, "_busy"}, busy, 1);
    if (v.err[1:0] == 2'b00) begin
      exp_t0 = 24'hFFFFFF - v.e0;
      exp_t1 = 24'hFFFFFF - v.e1;
      exp_gt = (exp_t0 > exp_t1) ? 2'b01 : (exp_t1 > exp_t0) ? 2'b10 : 2'b00;
    end
`ifdef SPEED_READER_TICKS_EN
    chk({tag, "_ticks0"}, ticks0, exp_t0);
    chk({tag, "_ticks1"}, ticks1, exp_t1);
    chk({tag, "_ticks_gt"}, ticks_gt, exp_gt);
`endif
    prev0 = v.e0; prev1 = v.e1;
    accept();
    m_arm_bad = 1'b0;
  endtask

  initial begin
    int   lat;
    vec_t v;

    //          c0         c1        fire arm dly err    lat  exp c0     exp c1
    tbl[0]  = '{24'hFFF000, 24'hFFF000, 1, 0, 0,  4'b0000, 21, 24'hFFF000, 24'hFFF000};
    tbl[1]  = '{24'hFFF000, 24'hFFEFF0, 1, 0, 0,  4'b1000, 21, 24'hFFF000, 24'hFFEFF0};
    tbl[2]  = '{24'h123456, 24'h654321, 0, 0, 0,  4'b0010, 23, 24'hFFF000, 24'hFFEFF0};
    tbl[3]  = '{24'h7FFFFF, 24'h7FFFFF, 1, 0, 0,  4'b0100, 21, 24'h7FFFFF, 24'h7FFFFF};
    tbl[4]  = '{24'hFFFFF0, 24'h000005, 1, 0, 0,  4'b1100, 21, 24'hFFFFF0, 24'h000005};
    tbl[5]  = '{24'hFFF003, 24'hFFF000, 1, 0, 0,  4'b0000, 21, 24'hFFF003, 24'hFFF000};
    tbl[6]  = '{24'hFFF000, 24'hFFF004, 1, 0, 0,  4'b1000, 21, 24'hFFF000, 24'hFFF004};
    tbl[7]  = '{24'hFFF100, 24'hFFF100, 1, 0, 5,  4'b0000, 26, 24'hFFF100, 24'hFFF100};
    tbl[8]  = '{24'h800000, 24'h800000, 1, 0, 15, 4'b0000, 36, 24'h800000, 24'h800000};
    tbl[9]  = '{24'h111111, 24'h222222, 1, 0, 16, 4'b0010, 23, 24'h800000, 24'h800000};
    tbl[10] = '{24'h111111, 24'h222222, 1, 1, 0,  4'b0001, 2,  24'h800000, 24'h800000};

    // Reset state
    #1;
    chk("reset_outputs", {busy, res_valid, st_nrst, st_trig, st_sel, st_ring_en, err}, 0);
    chk("reset_counts", {count0, count1}, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // Directed table
    for (int i = 0; i < 11; i++) verify($sformatf("vec%0d", i), tbl[i]);

    // Randomised runs against the reference rules
    for (int i = 0; i < 16; i++) begin
      v.c0      = 24'hFFFFFF - 24'($urandom_range(0, 'h3000));
      v.c1      = ($urandom_range(0, 9) == 0) ? 24'($urandom_range(0, 20))
                                               : v.c0 ^ 24'($urandom_range(0, 7));
      v.fire_en = ($urandom_range(0, 7) != 0);
      v.arm_bad = 1'b0;
      v.delay   = $urandom_range(0, 17);
      if (!v.fire_en || v.delay >= 16) begin
        v.err = 4'b0010; v.lat = 23; v.e0 = prev0; v.e1 = prev1;
      end else begin
        v.err = ref_err(v.c0, v.c1); v.lat = 21 + v.delay; v.e0 = v.c0; v.e1 = v.c1;
      end
      verify($sformatf("rnd%0d", i), v);
    end

    // Handshake: start while busy ignored, result held under back-pressure
    m_c0 = 24'hFFE000; m_c1 = 24'hFFE001; m_fire_en = 1; m_delay = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      start = (i == 5 || i == 12);
      if (res_valid) begin lat = i; break; end
    end
    start = 1'b0;
    chk("hs_latency", lat, 21);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hs_hold_valid", res_valid, 1);
      chk("hs_hold_data", {count0, count1, 4'(err)}, {24'hFFE000, 24'hFFE001, 4'b0000});
    end
    @(negedge clk); res_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0; start = 1'b0;
    chk("hs_release_valid", res_valid, 0);
    repeat (5) @(posedge clk);
    #1 chk("hs_no_queued_run", busy, 0);
    prev0 = 24'hFFE000; prev1 = 24'hFFE001;

    // Async reset in the middle of READ
    m_c0 = 24'hFFD000; m_c1 = 24'hFFD000;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("rst_mid_outputs", {busy, res_valid, st_nrst, st_trig, st_sel, st_ring_en, err}, 0);
    chk("rst_mid_counts", {count0, count1}, 0);
    @(negedge clk); nrst = 1'b1;
    prev0 = '0; prev1 = '0;
    exp_t0 = '0; exp_t1 = '0; exp_gt = '0;
`ifdef SPEED_READER_TICKS_EN
    #1 chk("rst_mid_ticks", {ticks0, ticks1, ticks_gt}, 0);
`endif
    verify("post_reset", tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
